uart_frame_unpack: RTL and testbench
====================================

UART_FRAME_UNPACK -- requirements
Module: uart_frame_unpack

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: CLK_MUXOUT is the clock, r_rst is the reset.
REQ-002 Parameter NBYTES SHALL default to 56 and SHALL set the payload bytes per frame; it SHALL be a multiple of 4 in the range 4..56.
REQ-003 Parameter HDR SHALL default to 8'hA5 and SHALL set the frame header byte.
REQ-004 Parameter TIMEOUT SHALL default to 50000 and SHALL set the maximum number of idle CLK_MUXOUT cycles allowed between bytes inside a frame.
REQ-005 Port CLK_MUXOUT: input, 1 bit, clock; all logic on the rising edge.
REQ-006 Port r_rst: input, 1 bit, synchronous active-high reset.
REQ-007 Port rx_valid: input, 1 bit, one-cycle strobe from the UART receiver meaning rx_data is valid.
REQ-008 Port rx_data: input, 8 bits, received byte; sampled only when rx_valid=1.
REQ-009 Port dout_bus: output, NBYTES*8 bits, committed payload; register i occupies bits [8i+7:8i].
REQ-010 Port dout_valid: output, 1 bit, one-cycle pulse when a good frame is committed.
REQ-011 Port frame_err: output, 1 bit, one-cycle pulse on a checksum mismatch or a timeout.
REQ-012 Port frame_cnt: output, 8 bits, count of good frames; wraps 255->0.
REQ-013 Port rx_busy: output, 1 bit, 1 whenever the FSM is not in IDLE.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, PAYLOAD and CHK.
REQ-015 In IDLE, rx_valid with rx_data==HDR SHALL move the FSM to PAYLOAD and clear the byte counter, the running sum and the timeout timer.
REQ-016 In IDLE, any other byte SHALL be ignored and cause no output change.
REQ-017 In PAYLOAD, the k-th accepted byte (k=0..NBYTES-1) SHALL be written to shadow register 4*(k/4)+3-(k%4), so each group of 4 is reversed (first byte lands in index 3, fourth byte in index 0).
REQ-018 In PAYLOAD, each accepted byte SHALL also update sum <= (sum + rx_data) mod 256 and increment k.
REQ-019 After the byte with k==NBYTES-1 is accepted, the FSM SHALL move to CHK.
REQ-020 An HDR-valued byte inside PAYLOAD SHALL be treated as ordinary payload.
REQ-021 In CHK, rx_valid with rx_data==sum SHALL, on the next rising edge, copy all shadow registers to dout_bus, pulse dout_valid for 1 cycle, increment frame_cnt and return the FSM to IDLE.
REQ-022 Latency from the checksum-byte strobe to dout_valid SHALL be exactly 1 cycle, and dout_bus SHALL change on the same edge that raises dout_valid.
REQ-023 In CHK, rx_valid with rx_data!=sum SHALL, on the next edge, pulse frame_err, leave dout_bus and frame_cnt unchanged and return the FSM to IDLE.
REQ-024 In PAYLOAD and CHK, the timeout timer SHALL clear on every rx_valid and otherwise increment by 1 per cycle.
REQ-025 When the timer reaches TIMEOUT-1 without an rx_valid, the FSM SHALL go to IDLE, pulse frame_err and discard the shadow contents; dout_bus SHALL be unchanged.
REQ-026 If rx_valid coincides with the cycle the timer reaches TIMEOUT-1, the byte SHALL be processed and no timeout SHALL occur.
REQ-027 The timer SHALL be held at 0 in IDLE and SHALL be wide enough for TIMEOUT (17 bits at the default).
REQ-028 dout_valid and frame_err SHALL never be 1 in the same cycle.
REQ-029 dout_bus SHALL hold its value indefinitely between good frames.
REQ-030 Shadow registers SHALL never be visible on dout_bus except through a commit.

Reset
REQ-031 r_rst sampled high SHALL, on that edge, set the FSM to IDLE and clear the byte counter, sum, timer, all shadow registers, dout_bus, frame_cnt, dout_valid, frame_err and rx_busy to 0.
REQ-032 An r_rst asserted mid-frame SHALL abandon the frame with no frame_err pulse.
REQ-033 r_rst SHALL take priority over rx_valid in the same cycle.
REQ-034 After r_rst deasserts, the block SHALL first accept an HDR byte on the first rx_valid.

Verification (bench uses NBYTES=8, TIMEOUT=100)
REQ-035 Good frame: A5,01,02,03,04,05,06,07,08,24 -> 1 cycle after the checksum strobe, dout_valid=1 and dout_bus bytes[0..7]=04,03,02,01,08,07,06,05; frame_cnt=1.
REQ-036 Bad checksum: the same frame with final byte 25 -> frame_err pulses 1 cycle; dout_bus keeps its prior value; frame_cnt is unchanged.
REQ-037 Timeout: A5,11,22 followed by 100 idle cycles -> frame_err at cycle 99 after the 22 strobe, rx_busy=0; then a good frame commits normally.
REQ-038 Noise and reset: bytes 00,FF,5A in IDLE -> no output change. Then A5,10,20,30 with r_rst pulsed before frame completion -> all outputs 0, no frame_err, FSM in IDLE.
REQ-039 Wrap and back-to-back: 256 good frames sent with 1 idle cycle between them -> frame_cnt wraps to 0 and every frame produces exactly one dout_valid.

Source files
------------

// File: rtl/uart_frame_unpack.sv
// uart_frame_unpack: collects a header-delimited UART frame of NBYTES payload
// bytes plus a mod-256 checksum, reverses every group of four bytes into a
// shadow bank and commits the bank to dout_bus only when the checksum matches.
module uart_frame_unpack #(
   parameter int         NBYTES  = 56,
   parameter logic [7:0] HDR     = 8'hA5,
   parameter int         TIMEOUT = 50000
) (
   input  logic                  CLK_MUXOUT,
   input  logic                  r_rst,
   input  logic                  rx_valid,
   input  logic [7:0]            rx_data,
   output logic [NBYTES*8-1:0]   dout_bus,
   output logic                  dout_valid,
   output logic                  frame_err,
   output logic [7:0]            frame_cnt,
   output logic                  rx_busy
);

   // One spare bit keeps the group/lane split valid down to NBYTES=4.
   localparam int KW = $clog2(NBYTES) + 1;
   localparam int TW = $clog2(TIMEOUT) + 1;

   typedef enum logic [1:0] {IDLE, PAYLOAD, CHK} state_t;

   state_t              r_state;
   state_t              w_state_next;
   logic [KW-1:0]       r_k;
   logic [7:0]          r_sum;
   logic [TW-1:0]       r_timer;
   logic [7:0]          r_shadow [NBYTES];
   logic [NBYTES*8-1:0] r_dout;
   logic                r_dout_valid;
   logic                r_frame_err;
   logic [7:0]          r_frame_cnt;

   logic                w_start;
   logic                w_accept;
   logic                w_commit;
   logic                w_bad;
   logic                w_timeout;
   logic [TW-1:0]       w_timer_inc;
   logic [KW-1:0]       w_idx;

   // Timeout fires on the edge where the timer would reach TIMEOUT-1 with no
   // byte arriving; a byte on that same edge wins and restarts the timer.
   assign w_timer_inc = r_timer + TW'(1);
   assign w_timeout   = (r_state != IDLE) && !rx_valid &&
                        (w_timer_inc == TW'(TIMEOUT - 1));

   // Lane 3-(k%4) within the group is just the inverted low two bits of k.
   assign w_idx = {r_k[KW-1:2], ~r_k[1:0]};

   // State register.
   always_ff @(posedge CLK_MUXOUT) begin
      // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
      if (r_rst) r_state <= IDLE;
      else       r_state <= w_state_next;
   end

   // Next-state decode and per-cycle action strobes.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      w_state_next = r_state;
      w_start      = 1'b0;
      w_accept     = 1'b0;
      w_commit     = 1'b0;
      w_bad        = 1'b0;
      case (r_state)
         IDLE: begin
            if (rx_valid && (rx_data == HDR)) begin
               w_start      = 1'b1;
               w_state_next = PAYLOAD;
            end
         end
         PAYLOAD: begin
            if (w_timeout) begin
               w_state_next = IDLE;
            end else if (rx_valid) begin
               w_accept = 1'b1;
               if (r_k == KW'(NBYTES - 1)) w_state_next = CHK;
            end
         end
         CHK: begin
            if (w_timeout) begin
               w_state_next = IDLE;
            end else if (rx_valid) begin
               if (rx_data == r_sum) w_commit = 1'b1;
               else                  w_bad    = 1'b1;
               w_state_next = IDLE;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   // Byte counter, running checksum and inter-byte timer.
   always_ff @(posedge CLK_MUXOUT) begin
      if (r_rst) begin
         r_k     <= '0;
         r_sum   <= '0;
         r_timer <= '0;
      end else begin
         if (w_start) begin
            r_k   <= '0;
            r_sum <= '0;
         end else if (w_accept) begin
            r_k   <= r_k + KW'(1);
            r_sum <= r_sum + rx_data;
         end
         if (r_state == IDLE || rx_valid || w_timeout) r_timer <= '0;
         else                                          r_timer <= w_timer_inc;
      end
   end

   // Shadow bank; an abandoned frame needs no clearing because a commit is
   // only reachable after all NBYTES lanes have been rewritten.
   always_ff @(posedge CLK_MUXOUT) begin
      // NOTE: this small register bank is reset explicitly because its contents must read 0 after reset; a RAM would not be.
      if (r_rst) begin
         for (int i = 0; i < NBYTES; i++) r_shadow[i] <= '0;
      end else begin
         for (int i = 0; i < NBYTES; i++)
            if (w_accept && (w_idx == KW'(i))) r_shadow[i] <= rx_data;
      end
   end

   // Commit path: output bus, status pulses and good-frame counter.
   always_ff @(posedge CLK_MUXOUT) begin
      if (r_rst) begin
         r_dout       <= '0;
         r_dout_valid <= 1'b0;
         r_frame_err  <= 1'b0;
         r_frame_cnt  <= '0;
      end else begin
         r_dout_valid <= w_commit;
         r_frame_err  <= w_bad || w_timeout;
         if (w_commit) begin
            for (int i = 0; i < NBYTES; i++) r_dout[8*i +: 8] <= r_shadow[i];
            r_frame_cnt <= r_frame_cnt + 8'd1;
         end
      end
   end

   assign dout_bus   = r_dout;
   assign dout_valid = r_dout_valid;
   assign frame_err  = r_frame_err;
   assign frame_cnt  = r_frame_cnt;
   assign rx_busy    = (r_state != IDLE);

endmodule

// File: tb/tb_uart_frame_unpack.sv
// Directed bench for uart_frame_unpack (NBYTES=8, TIMEOUT=100) with a
// scoreboard of expected commits checked by a dout_valid monitor.
module tb_uart_frame_unpack;

   localparam int         NB  = 8;
   localparam int         TO  = 100;
   localparam logic [7:0] HDR = 8'hA5;

   logic            CLK_MUXOUT = 1'b0;
   logic            r_rst;
   logic            rx_valid;
   logic [7:0]      rx_data;
   logic [NB*8-1:0] dout_bus;
   logic            dout_valid;
   logic            frame_err;
   logic [7:0]      frame_cnt;
   logic            rx_busy;

   typedef struct {
      logic [63:0] bus;
      logic [7:0]  cnt;
   } exp_t;

   exp_t     sb_q[$];
   int       n_checks = 0;
   int       n_errors = 0;
   int       n_commits = 0;
   logic [7:0] m_cnt = 8'd0;

   uart_frame_unpack #(.NBYTES(NB), .HDR(HDR), .TIMEOUT(TO)) dut (
      .CLK_MUXOUT (CLK_MUXOUT),
      .r_rst      (r_rst),
      .rx_valid   (rx_valid),
      .rx_data    (rx_data),
      .dout_bus   (dout_bus),
      .dout_valid (dout_valid),
      .frame_err  (frame_err),
      .frame_cnt  (frame_cnt),
      .rx_busy    (rx_busy)
   );

   always #5 CLK_MUXOUT = ~CLK_MUXOUT;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Byte k of payload p lands in lane 4*(k/4)+3-(k%4).
   function automatic logic [63:0] exp_bus(input logic [63:0] p);
      logic [63:0] r;
      int idx;
      r = '0;
      for (int k = 0; k < NB; k++) begin
         idx = 4 * (k / 4) + 3 - (k % 4);
         r[8*idx +: 8] = p[8*k +: 8];
      end
      return r;
   endfunction

   function automatic logic [7:0] csum(input logic [63:0] p);
      logic [7:0] s;
      s = 8'd0;
      for (int k = 0; k < NB; k++) s = s + p[8*k +: 8];
      return s;
   endfunction

   task automatic send_byte(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_data  = b;
      @(posedge CLK_MUXOUT);
      #1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge CLK_MUXOUT);
         #1;
      end
   endtask

   // Header, payload and checksum; a good frame is pushed to the scoreboard.
   task automatic send_frame(input logic [63:0] p, input bit good);
      exp_t e;
      send_byte(HDR);
      for (int k = 0; k < NB; k++) send_byte(p[8*k +: 8]);
      if (good) begin
         m_cnt = m_cnt + 8'd1;
         e.bus = exp_bus(p);
         e.cnt = m_cnt;
         sb_q.push_back(e);
         send_byte(csum(p));
      end else begin
         send_byte(csum(p) + 8'd1);
      end
   endtask

   // Commit monitor: every dout_valid pulse must match the oldest expectation.
   always @(negedge CLK_MUXOUT) begin
      exp_t e;
      if (dout_valid || frame_err) check("valid_err_exclusive", 64'(dout_valid && frame_err), 64'd0);
      if (dout_valid) begin
         n_commits++;
         if (sb_q.size() == 0) begin
            check("unexpected_commit", 64'd1, 64'd0);
         end else begin
            e = sb_q.pop_front();
            check("sb_dout_bus", dout_bus, e.bus);
            check("sb_frame_cnt", 64'(frame_cnt), 64'(e.cnt));
         end
      end
   end

   initial begin
      logic [63:0] p;
      logic [63:0] held;
      logic        saw_err;
      int          base;

      r_rst    = 1'b1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      idle(2);
      r_rst = 1'b0;
      check("rst_dout_bus", dout_bus, 64'd0);
      check("rst_dout_valid", 64'(dout_valid), 64'd0);
      check("rst_frame_err", 64'(frame_err), 64'd0);
      check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
      check("rst_rx_busy", 64'(rx_busy), 64'd0);

      // Noise in IDLE is ignored.
      send_byte(8'h00);
      send_byte(8'hFF);
      send_byte(8'h5A);
      check("noise_rx_busy", 64'(rx_busy), 64'd0);
      check("noise_err", 64'(frame_err), 64'd0);
      check("noise_bus", dout_bus, 64'd0);

      // Good frame with known layout.
      p = 64'h0807060504030201;
      send_byte(HDR);
      check("hdr_rx_busy", 64'(rx_busy), 64'd1);
      send_byte(HDR);   // header value inside payload is ordinary data
      for (int k = 1; k < NB; k++) send_byte(p[8*k +: 8]);
      check("chk_no_early_commit", 64'(dout_valid), 64'd0);
      // Replace byte 0 (01) by A5 in the expectation: checksum over A5,02..08.
      p[7:0] = HDR;
      m_cnt = m_cnt + 8'd1;
      sb_q.push_back('{bus: exp_bus(p), cnt: m_cnt});
      send_byte(csum(p));
      check("good_hdr_payload_valid", 64'(dout_valid), 64'd1);

      idle(1);
      p = 64'h0807060504030201;
      send_frame(p, 1'b1);
      check("good_valid_latency", 64'(dout_valid), 64'd1);
      check("good_bus_layout", dout_bus, 64'h0506070801020304);
      check("good_frame_cnt", 64'(frame_cnt), 64'd2);
      check("good_rx_busy", 64'(rx_busy), 64'd0);
      idle(1);
      check("good_valid_pulse", 64'(dout_valid), 64'd0);
      check("good_bus_hold", dout_bus, 64'h0506070801020304);

      // Bad checksum (final byte 25).
      send_frame(p, 1'b0);
      check("bad_frame_err", 64'(frame_err), 64'd1);
      check("bad_no_valid", 64'(dout_valid), 64'd0);
      check("bad_bus_kept", dout_bus, 64'h0506070801020304);
      check("bad_cnt_kept", 64'(frame_cnt), 64'd2);
      idle(1);
      check("bad_err_pulse", 64'(frame_err), 64'd0);

      // Timeout: error on the 99th cycle after the last strobe.
      held = dout_bus;
      send_byte(HDR);
      send_byte(8'h11);
      send_byte(8'h22);
      saw_err = 1'b0;
      for (int d = 1; d <= TO - 2; d++) begin
         @(posedge CLK_MUXOUT);
         #1;
         saw_err = saw_err | frame_err;
      end
      check("to_no_early_err", 64'(saw_err), 64'd0);
      check("to_busy_before", 64'(rx_busy), 64'd1);
      idle(1);
      check("to_frame_err", 64'(frame_err), 64'd1);
      check("to_rx_busy", 64'(rx_busy), 64'd0);
      check("to_bus_kept", dout_bus, held);
      idle(1);
      check("to_err_pulse", 64'(frame_err), 64'd0);
      p = 64'h1122334455667788;
      send_frame(p, 1'b1);
      check("to_recover_valid", 64'(dout_valid), 64'd1);

      // Byte on the exact timeout edge is processed instead.
      idle(1);
      p = 64'hA1B2C3D4E5F60711;
      send_byte(HDR);
      send_byte(p[7:0]);
      saw_err = 1'b0;
      for (int d = 1; d <= TO - 2; d++) begin
         @(posedge CLK_MUXOUT);
         #1;
         saw_err = saw_err | frame_err;
      end
      for (int k = 1; k < NB; k++) begin
         send_byte(p[8*k +: 8]);
         saw_err = saw_err | frame_err;
      end
      m_cnt = m_cnt + 8'd1;
      sb_q.push_back('{bus: exp_bus(p), cnt: m_cnt});
      send_byte(csum(p));
      check("edge_byte_no_err", 64'(saw_err | frame_err), 64'd0);
      check("edge_byte_commit", 64'(dout_valid), 64'd1);

      // Reset mid-frame, with a header byte on the reset cycle.
      idle(1);
      send_byte(HDR);
      send_byte(8'h10);
      send_byte(8'h20);
      send_byte(8'h30);
      r_rst    = 1'b1;
      rx_valid = 1'b1;
      rx_data  = HDR;
      @(posedge CLK_MUXOUT);
      #1;
      r_rst    = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      m_cnt    = 8'd0;
      check("mid_rst_bus", dout_bus, 64'd0);
      check("mid_rst_cnt", 64'(frame_cnt), 64'd0);
      check("mid_rst_busy", 64'(rx_busy), 64'd0);
      check("mid_rst_err", 64'(frame_err), 64'd0);
      check("mid_rst_valid", 64'(dout_valid), 64'd0);
      idle(1);
      check("mid_rst_no_err", 64'(frame_err), 64'd0);
      send_byte(8'h01);
      check("post_rst_needs_hdr", 64'(rx_busy), 64'd0);

      // 256 back-to-back good frames: counter wraps to 0.
      base = n_commits;
      for (int f = 0; f < 256; f++) begin
         p = {$urandom, $urandom};
         send_frame(p, 1'b1);
         idle(1);
      end
      check("wrap_frame_cnt", 64'(frame_cnt), 64'd0);
      check("wrap_one_valid_each", 64'(n_commits - base), 64'd256);
      check("sb_drained", 64'(sb_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
